ifu_fetch_queue: RTL and testbench
==================================

Name: ifu_fetch_queue

Overview:
Parametrised successor to the single-register fetch PC. Holds the fetch PC and drives the instruction-memory address. Captures each fetched {pc, instr} pair into a DEPTH-entry FIFO, and presents the FIFO to decode with a valid/ready handshake. Supports pipeline stall, redirect (branch/jump/exception) with queue flush, and configurable PC width, reset vector and increment.

Parameters:
PC_W, 32, PC and address width in bits
RESET_PC, 32'h00003000, PC value loaded on reset
INC, 4, PC increment per fetched instruction
DEPTH, 4, FIFO entries; power of two, >= 2
INSTR_W, 32, instruction width

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-low reset
stall  in  1  freeze the fetch PC and suppress pushes; pops continue
redirect_valid  in  1  load redirect_pc and flush the queue
redirect_pc  in  PC_W  redirect target
fetch_pc  out  PC_W  current fetch PC, drives the IM address
im_rdata  in  INSTR_W  instruction at fetch_pc, combinational from IM in the same cycle
out_valid  out  1  head entry valid
out_ready  in  1  decode accepts the head entry
out_pc  out  PC_W  PC of the head entry
out_instr  out  INSTR_W  instruction of the head entry
out_adel  out  1  head entry has a misaligned PC (optional feature)
count  out  clog2(DEPTH)+1  number of occupied entries
full  out  1  count == DEPTH

Behaviour:
- Reset (reset==0, asynchronous): fetch_pc=RESET_PC; head, tail and count=0; all valid bits cleared; out_valid=0, full=0; out_pc, out_instr and out_adel=0.
- The current-state signals are registered: fetch_pc, the head/tail pointers and count.
- out_pc, out_instr and out_adel read the head entry, and are 0 when count==0.
- out_valid = (count != 0).
- push = !redirect_valid && !stall && !full. On push:
  - entry[tail] <= {fetch_pc, im_rdata, adel}
  - tail advances by 1, wrapping modulo DEPTH
  - fetch_pc <= fetch_pc + INC, truncated to PC_W (wraps at 2^PC_W)
- Without a push and without a redirect, fetch_pc holds.
- pop = out_valid && out_ready && !redirect_valid. On pop, head advances by 1, wrapping modulo DEPTH.
- count next state:
  - count+1 on push only
  - count-1 on pop only
  - unchanged on push and pop together, or on neither
- No bypass: an entry pushed in cycle N is first visible on out_* in cycle N+1. Fetch-to-decode latency is therefore 1 cycle when the queue is empty.
- full is evaluated from the registered count. With count==DEPTH, push is blocked even if a pop occurs in the same cycle, so the freed slot is refilled the following cycle.
- redirect_valid has highest priority and overrides both stall and a full queue. The next state is:
  - fetch_pc <= redirect_pc
  - head, tail and count <= 0, i.e. the queue is flushed
  - no push and no pop; a concurrent out_ready handshake is discarded and decode must not consume the entry
- stall with no redirect: fetch_pc and tail hold and im_rdata is ignored; pops proceed normally.
- Reset asserted mid-operation immediately restores the reset state, discarding queue contents. The first fetch after reset deassertion uses RESET_PC.
- Outstanding entries are never reordered or duplicated. Entries are delivered in strict PC order between redirects.

Optional Feature:
IFU_ALIGN_CHECK_EN
- Defined: adel for each pushed entry = |fetch_pc[1:0]. out_adel reflects the head entry's flag.
- The misaligned entry is still queued and fetch continues at fetch_pc+INC.
- Undefined: no alignment logic and no flag storage; out_adel is tied to 0.

Test Plan:
- Reset, then 3 cycles with stall=0, out_ready=0, im_rdata = fetch_pc ^ 32'hFFFF0000 -> fetch_pc 3000, 3004, 3008, 300C; count 0, 1, 2, 3; out_pc=3000, out_instr=FFFF3000.
- Fill with out_ready=0, DEPTH=4 -> full=1 and count=4 after 4 pushes; fetch_pc holds at 3010. Raise out_ready for 1 cycle -> out_pc 3000 becomes 3004 and count=3. Next cycle a push of 3010 gives count=4.
- Steady flow with out_ready=1, stall=0 -> count stays 1; out_pc advances by 4 every cycle, 1 cycle behind fetch_pc.
- Queue holds 3004..3010, redirect_valid=1 with redirect_pc=00004000 while stall=1 and out_ready=1 -> next cycle count=0, out_valid=0, fetch_pc=4000. The following cycle out_pc=4000.
- stall=1 for 5 cycles with 2 entries and out_ready=1 -> both entries drain; fetch_pc is unchanged and count=0. After release, fetching resumes at the held PC.
- With IFU_ALIGN_CHECK_EN, redirect_pc=00004002 -> the entry at 4002 has out_adel=1 and the next entry at 4006 also has out_adel=1. Redirect to 4000 -> out_adel=0. Without the macro, out_adel=0 throughout.
- Assert reset while count=3 -> all outputs return to reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/ifu_fetch_queue.sv
// Fetch PC register plus a DEPTH-entry {pc, instr} queue feeding decode; 1-cycle fetch-to-decode latency, no bypass.
// Backpressure: full or stall blocks pushes and holds fetch_pc; redirect flushes and overrides everything.
// Optional alignment flag per entry when IFU_ALIGN_CHECK_EN is defined; otherwise out_adel is tied to 0.
module ifu_fetch_queue #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_3000,
  parameter int              INC      = 4,
  parameter int              DEPTH    = 4,
  parameter int              INSTR_W  = 32,
  localparam int             PTR_W    = $clog2(DEPTH),
  localparam int             CNT_W    = PTR_W + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    fetch_pc,
  input  logic [INSTR_W-1:0] im_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_adel,
  output logic [CNT_W-1:0]   count,
  output logic               full
);

  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop;

  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  assign full      = (count_q == CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = !redirect_valid && !stall && !full;
  assign pop       = out_valid && out_ready && !redirect_valid;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        tail_d     = tail_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + PC_W'(INC);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Entry payload needs no reset: out_* are masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]    <= fetch_pc_q;
      instr_mem[tail_q] <= im_rdata;
    end
  end

  assign fetch_pc  = fetch_pc_q;
  assign count     = count_q;
  assign out_pc    = out_valid ? pc_mem[head_q]    : '0;
  assign out_instr = out_valid ? instr_mem[head_q] : '0;

`ifdef IFU_ALIGN_CHECK_EN
  logic adel_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (push) begin
      adel_mem[tail_q] <= |fetch_pc_q[1:0];
    end
  end

  assign out_adel = out_valid ? adel_mem[head_q] : 1'b0;
`else
  assign out_adel = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue with default parameters (DEPTH=4, INC=4, RESET_PC=3000).
module tb_ifu_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_pc;
  logic [31:0] im_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_adel;
  logic [2:0]  count;
  logic        full;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  assign im_rdata = fetch_pc ^ 32'hFFFF_0000;

  ifu_fetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_pc       (fetch_pc),
    .im_rdata       (im_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_adel       (out_adel),
    .count          (count),
    .full           (full)
  );

`ifdef IFU_ALIGN_CHECK_EN
  localparam logic ADEL_ON = 1'b1;
`else
  localparam logic ADEL_ON = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [31:0] e_pc, input logic [2:0] e_cnt,
                             input logic [31:0] e_out_pc);
    check({tag, ".fetch_pc"}, fetch_pc, e_pc);
    check({tag, ".count"}, 32'(count), 32'(e_cnt));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(e_cnt != 0));
    check({tag, ".full"}, 32'(full), 32'(e_cnt == 3'd4));
    check({tag, ".out_pc"}, out_pc, e_out_pc);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    #12;
    check_state("rst", 32'h3000, 3'd0, 32'h0);
    check("rst.out_instr", out_instr, 32'h0);
    check("rst.out_adel", 32'(out_adel), 32'h0);
    reset = 1'b1;

    // fill with decode not ready
    tick(); check_state("f1", 32'h3004, 3'd1, 32'h3000);
    check("f1.out_instr", out_instr, 32'hFFFF_3000);
    tick(); check_state("f2", 32'h3008, 3'd2, 32'h3000);
    tick(); check_state("f3", 32'h300C, 3'd3, 32'h3000);
    tick(); check_state("f4", 32'h3010, 3'd4, 32'h3000);
    tick(); check_state("fhold", 32'h3010, 3'd4, 32'h3000);

    // pop while full: no push that cycle, refill the next
    out_ready = 1'b1;
    tick(); check_state("popfull", 32'h3010, 3'd3, 32'h3004);
    out_ready = 1'b0;
    tick(); check_state("refill", 32'h3014, 3'd4, 32'h3004);

    // redirect beats stall and a concurrent handshake
    redirect_valid = 1'b1; redirect_pc = 32'h4000; stall = 1'b1; out_ready = 1'b1;
    tick(); check_state("redir", 32'h4000, 3'd0, 32'h0);
    redirect_valid = 1'b0; stall = 1'b0;

    // steady flow: one entry in flight, out_pc one step behind fetch_pc
    for (int i = 0; i < 4; i++) begin
      tick();
      check_state("flow", 32'h4004 + 32'(4 * i), 3'd1, 32'h4000 + 32'(4 * i));
    end
    check("flow.out_instr", out_instr, 32'hFFFF_400C);

    out_ready = 1'b0;
    tick(); check_state("two", 32'h4014, 3'd2, 32'h400C);

    // stall drains the queue but freezes the PC
    stall = 1'b1; out_ready = 1'b1;
    tick(); check_state("st1", 32'h4014, 3'd1, 32'h4010);
    tick(); check_state("st2", 32'h4014, 3'd0, 32'h0);
    tick(); tick(); tick();
    check_state("st5", 32'h4014, 3'd0, 32'h0);
    stall = 1'b0; out_ready = 1'b0;
    tick(); check_state("resume", 32'h4018, 3'd1, 32'h4014);
    check("resume.out_instr", out_instr, 32'hFFFF_4014);

    // misaligned redirect target
    redirect_valid = 1'b1; redirect_pc = 32'h4002;
    tick(); check_state("rmis", 32'h4002, 3'd0, 32'h0);
    redirect_valid = 1'b0;
    tick(); check_state("mis1", 32'h4006, 3'd1, 32'h4002);
    check("mis1.adel", 32'(out_adel), 32'(ADEL_ON));
    out_ready = 1'b1;
    tick(); check_state("mis2", 32'h400A, 3'd1, 32'h4006);
    check("mis2.adel", 32'(out_adel), 32'(ADEL_ON));
    redirect_valid = 1'b1; redirect_pc = 32'h4000;
    tick(); check_state("ral", 32'h4000, 3'd0, 32'h0);
    redirect_valid = 1'b0; out_ready = 1'b0;
    tick(); check_state("al1", 32'h4004, 3'd1, 32'h4000);
    check("al1.adel", 32'(out_adel), 32'h0);

    // PC wraps at 2^32
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(); check_state("rwrap", 32'hFFFF_FFFC, 3'd0, 32'h0);
    redirect_valid = 1'b0;
    tick(); check_state("wrap", 32'h0000_0000, 3'd1, 32'hFFFF_FFFC);
    tick(); check_state("wrap2", 32'h0000_0004, 3'd2, 32'hFFFF_FFFC);
    tick(); check_state("wrap3", 32'h0000_0008, 3'd3, 32'hFFFF_FFFC);

    // async reset mid-cycle with three entries queued
    #2 reset = 1'b0;
    #1;
    check_state("arst", 32'h3000, 3'd0, 32'h0);
    check("arst.out_instr", out_instr, 32'h0);
    check("arst.out_adel", 32'(out_adel), 32'h0);
    #3 reset = 1'b1;
    tick(); check_state("post", 32'h3004, 3'd1, 32'h3000);
    check("post.out_instr", out_instr, 32'hFFFF_3000);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
